// File: rtl/debug_trace_buffer.sv
// rtl/debug_trace_buffer.sv - circular probe trace buffer with arm/trigger/post-count capture and valid/ready drain
// Optional DEBUG_TRACE_DISPLAY_EN: simulation printout of every trace write, trigger and DONE entry.
module debug_trace_buffer #(
    parameter int NUM_CH = 8,
    parameter int CH_W   = 4,
    parameter int DEPTH  = 64,
    parameter int TS_W   = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           debug_enable,
    input  logic [NUM_CH*CH_W-1:0]         probe,
    input  logic [NUM_CH-1:0]              ch_mask,
    input  logic                           change_only,
    input  logic                           arm,
    input  logic                           trig_in,
    input  logic [$clog2(DEPTH)-1:0]       post_cnt,
    input  logic                           rd_ready,
    output logic                           rd_valid,
    output logic [TS_W+NUM_CH*CH_W-1:0]    rd_data,
    output logic                           rd_last,
    output logic [1:0]                     state,
    output logic [$clog2(DEPTH):0]         fill_count,
    output logic                           wrapped,
    output logic [31:0]                    main_cycle_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = NUM_CH * CH_W;
    localparam int EW = TS_W + PW;
    localparam logic [AW:0] FILL_FULL    = (AW+1)'(DEPTH);
    localparam logic [AW:0] FILL_FULL_M1 = (AW+1)'(DEPTH - 1);
    localparam logic [AW:0] FILL_ONE     = (AW+1)'(1);
    localparam logic [AW:0] FILL_TWO     = (AW+1)'(2);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        POST  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          st;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   post_rem;
    logic            first_smp;
    logic [PW-1:0]   prev_masked;
    logic [EW-1:0]   mem [DEPTH];

    logic [PW-1:0]   mask_exp;
    logic [PW-1:0]   masked;
    logic            changed;
    logic            capturing;
    logic            trig_hit;
    logic            do_write;
    logic [EW-1:0]   sample;
    logic [AW-1:0]   rd_start;
    logic [AW-1:0]   rd_next;

    assign state = st;

    // Widen the per-channel mask to one bit per probe bit
    always_comb begin
        mask_exp = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            mask_exp[k*CH_W +: CH_W] = {CH_W{ch_mask[k]}};
        end
    end

    assign masked    = probe & mask_exp;
    assign changed   = (masked != prev_masked);
    assign capturing = (st == ARMED) || (st == POST);
    assign trig_hit  = (st == ARMED) && trig_in;
    // arm wins over everything, so the arm cycle itself never stores a sample
    assign do_write  = debug_enable && !arm && capturing &&
                       (!change_only || first_smp || changed || trig_hit);
    assign sample    = {main_cycle_cnt[TS_W-1:0], probe};
    assign rd_start  = wrapped ? wr_ptr : '0;
    assign rd_next   = rd_ptr + 1'b1;

    // Trace RAM write port; contents are deliberately left unreset
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[wr_ptr] <= sample;
        end
    end

    // Capture/readout FSM, pointers, counters and registered readout port
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st             <= IDLE;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            post_rem       <= '0;
            first_smp      <= 1'b0;
            prev_masked    <= '0;
            fill_count     <= '0;
            wrapped        <= 1'b0;
            rd_valid       <= 1'b0;
            rd_last        <= 1'b0;
            rd_data        <= '0;
            main_cycle_cnt <= '0;
        end else if (debug_enable) begin
            main_cycle_cnt <= main_cycle_cnt + 32'd1;
            prev_masked    <= masked;
            if (arm) begin
                st         <= ARMED;
                wr_ptr     <= '0;
                fill_count <= '0;
                wrapped    <= 1'b0;
                post_rem   <= '0;
                first_smp  <= 1'b1;
                rd_valid   <= 1'b0;
                rd_last    <= 1'b0;
            end else begin
                first_smp <= 1'b0;
                if (do_write) begin
                    wr_ptr <= wr_ptr + 1'b1;
                    if (fill_count != FILL_FULL) begin
                        fill_count <= fill_count + 1'b1;
                    end
                    if (fill_count >= FILL_FULL_M1) begin
                        wrapped <= 1'b1;
                    end
                end
                case (st)
                    ARMED: begin
                        if (trig_in) begin
                            if (post_cnt == '0) begin
                                st <= DONE;
                            end else begin
                                st       <= POST;
                                post_rem <= post_cnt;
                            end
                        end
                    end
                    POST: begin
                        if (do_write) begin
                            post_rem <= post_rem - 1'b1;
                            if (post_rem == AW'(1)) begin
                                st <= DONE;
                            end
                        end
                    end
                    DONE: begin
                        if (!rd_valid) begin
                            // first DONE cycle: load the oldest entry
                            rd_ptr   <= rd_start;
                            rd_data  <= mem[rd_start];
                            rd_valid <= 1'b1;
                            rd_last  <= (fill_count == FILL_ONE);
                        end else if (rd_ready) begin
                            if (fill_count == FILL_ONE) begin
                                st         <= IDLE;
                                rd_valid   <= 1'b0;
                                rd_last    <= 1'b0;
                                fill_count <= '0;
                            end else begin
                                rd_ptr     <= rd_next;
                                rd_data    <= mem[rd_next];
                                fill_count <= fill_count - 1'b1;
                                rd_last    <= (fill_count == FILL_TWO);
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef DEBUG_TRACE_DISPLAY_EN
    // Simulation-only trace printout of writes, trigger and DONE entry
    always @(posedge clk) begin
        if (rst_n) begin
            if (do_write) begin
                $write("[TRACE][%0d]", main_cycle_cnt[TS_W-1:0]);
                for (int k = 0; k < NUM_CH; k++) begin
                    $write(" ch%0d=%h", k, probe[k*CH_W +: CH_W]);
                end
                $write("\n");
            end
            if (debug_enable && !arm && trig_hit) begin
                $display("[TRACE][%0d] trigger", main_cycle_cnt[TS_W-1:0]);
            end
            if (debug_enable && !arm && (st == DONE) && !rd_valid) begin
                $display("[TRACE][%0d] done, %0d entries", main_cycle_cnt[TS_W-1:0], fill_count);
            end
        end
    end
`endif

endmodule

// File: tb/tb_debug_trace_buffer.sv
// tb/tb_debug_trace_buffer.sv - table-driven and directed checks for debug_trace_buffer
module tb_debug_trace_buffer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        debug_enable;
    logic [31:0] probe;
    logic [7:0]  ch_mask;
    logic        change_only;
    logic        arm;
    logic        trig_in;
    logic [5:0]  post_cnt;
    logic        rd_ready;
    logic        rd_valid;
    logic [47:0] rd_data;
    logic        rd_last;
    logic [1:0]  state;
    logic [6:0]  fill_count;
    logic        wrapped;
    logic [31:0] main_cycle_cnt;

    int tests = 0;
    int fails = 0;
    logic [31:0] tb_cyc;
    logic [31:0] exp_p[$];
    logic [15:0] exp_t[$];

    typedef struct {
        logic        arm;
        logic        trig;
        logic [31:0] probe;
        logic        rec;
        logic [1:0]  st;
        int          fill;
        logic        vld;
    } vec_t;

    vec_t vec[$];

    debug_trace_buffer #(.NUM_CH(8), .CH_W(4), .DEPTH(64), .TS_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .debug_enable(debug_enable), .probe(probe),
        .ch_mask(ch_mask), .change_only(change_only), .arm(arm), .trig_in(trig_in),
        .post_cnt(post_cnt), .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data),
        .rd_last(rd_last), .state(state), .fill_count(fill_count), .wrapped(wrapped),
        .main_cycle_cnt(main_cycle_cnt)
    );

    always #5 clk = ~clk;

    // Reference cycle counter
    always @(posedge clk) begin
        if (!rst_n) tb_cyc <= 32'd0;
        else if (debug_enable) tb_cyc <= tb_cyc + 32'd1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic a, input logic t, input logic [31:0] p,
                                input logic r, input logic [1:0] s, input int f, input logic v);
        vec_t x;
        x.arm = a; x.trig = t; x.probe = p; x.rec = r; x.st = s; x.fill = f; x.vld = v;
        return x;
    endfunction

    task automatic apply_row(input vec_t v, input int idx);
        arm     = v.arm;
        trig_in = v.trig;
        probe   = v.probe;
        if (v.rec) begin
            exp_p.push_back(v.probe);
            exp_t.push_back(tb_cyc[15:0]);
        end
        step();
        arm     = 1'b0;
        trig_in = 1'b0;
        check($sformatf("row%0d state", idx), state, v.st);
        check($sformatf("row%0d fill", idx), fill_count, v.fill);
        check($sformatf("row%0d valid", idx), rd_valid, v.vld);
    endtask

    task automatic record_step(input logic [31:0] p, input logic t);
        probe   = p;
        trig_in = t;
        exp_p.push_back(p);
        exp_t.push_back(tb_cyc[15:0]);
        step();
        trig_in = 1'b0;
    endtask

    task automatic drain(input bit toggle, input string tag);
        int n;
        int got;
        int cyc;
        n = exp_p.size();
        got = 0;
        cyc = 0;
        while (got < n && cyc < 400) begin
            rd_ready = toggle ? ((cyc % 2) == 0) : 1'b1;
            if (rd_valid && rd_ready) begin
                check($sformatf("%s data%0d", tag, got), rd_data, {exp_t[got], exp_p[got]});
                check($sformatf("%s last%0d", tag, got), rd_last, (got == n - 1));
                got++;
            end
            step();
            cyc++;
        end
        rd_ready = 1'b0;
        check({tag, " count"}, got, n);
        check({tag, " idle"}, state, 2'd0);
        check({tag, " valid low"}, rd_valid, 1'b0);
        check({tag, " fill zero"}, fill_count, 0);
        exp_p.delete();
        exp_t.delete();
    endtask

    int part_a;

    initial begin
        rst_n = 1'b0; debug_enable = 1'b1; probe = '0; ch_mask = 8'hFF; change_only = 1'b0;
        arm = 1'b0; trig_in = 1'b0; post_cnt = 6'd5; rd_ready = 1'b0;
        repeat (3) step();
        check("rst state", state, 2'd0);
        check("rst valid", rd_valid, 1'b0);
        check("rst last", rd_last, 1'b0);
        check("rst data", rd_data, 48'd0);
        check("rst fill", fill_count, 0);
        check("rst wrapped", wrapped, 1'b0);
        check("rst cnt", main_cycle_cnt, 32'd0);
        rst_n = 1'b1;
        step();

        // Table A: every-cycle capture, trigger at sample 10, post_cnt=5
        vec.push_back(mk(1, 0, 32'd0, 0, 2'd1, 0, 0));
        for (int k = 0; k < 16; k++) begin
            vec.push_back(mk(0, (k == 10), 32'(k), 1,
                             (k < 10) ? 2'd1 : ((k < 15) ? 2'd2 : 2'd3), k + 1, 0));
        end
        vec.push_back(mk(0, 0, 32'd0, 0, 2'd3, 16, 1));
        part_a = vec.size();
        // Table B: arm+trig together is ARMED, later trig moves to POST, post_cnt=2
        vec.push_back(mk(1, 1, 32'hA0, 0, 2'd1, 0, 0));
        vec.push_back(mk(0, 0, 32'hA1, 0, 2'd1, 1, 0));
        vec.push_back(mk(0, 1, 32'hA2, 0, 2'd2, 2, 0));
        vec.push_back(mk(0, 0, 32'hA3, 0, 2'd2, 3, 0));
        vec.push_back(mk(0, 0, 32'hA4, 0, 2'd3, 4, 0));
        vec.push_back(mk(0, 0, 32'hA5, 0, 2'd3, 4, 1));

        for (int i = 0; i < part_a; i++) apply_row(vec[i], i);
        check("a cnt", main_cycle_cnt, tb_cyc);
        drain(1'b1, "a");

        post_cnt = 6'd2;
        for (int i = part_a; i < vec.size(); i++) apply_row(vec[i], i);
        rd_ready = 1'b1;
        step();
        step();
        rd_ready = 1'b0;
        check("b half fill", fill_count, 2);
        check("b half valid", rd_valid, 1'b1);
        arm = 1'b1;
        step();
        arm = 1'b0;
        check("b rearm state", state, 2'd1);
        check("b rearm fill", fill_count, 0);
        check("b rearm valid", rd_valid, 1'b0);
        step();
        check("b rearm first write", fill_count, 1);
        exp_p.delete();
        exp_t.delete();

        // Wrap: 100 pre-trigger samples, trigger sample 100, post_cnt=3
        post_cnt = 6'd3;
        arm = 1'b1;
        step();
        arm = 1'b0;
        for (int k = 0; k < 104; k++) record_step(32'(k), (k == 100));
        check("w state", state, 2'd3);
        check("w fill", fill_count, 64);
        check("w wrapped", wrapped, 1'b1);
        while (exp_p.size() > 64) begin
            void'(exp_p.pop_front());
            void'(exp_t.pop_front());
        end
        check("w oldest expect", exp_p[0], 32'd40);
        step();
        drain(1'b0, "w");

        // Change-only: only ch0 is watched; ch1 toggling must not store
        change_only = 1'b1;
        ch_mask = 8'h01;
        post_cnt = 6'd0;
        probe = 32'h0;
        arm = 1'b1;
        step();
        arm = 1'b0;
        record_step(32'h0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            probe = ((i % 2) == 0) ? 32'h10 : 32'h00;
            step();
        end
        check("c toggles ignored", fill_count, 1);
        check("c state armed", state, 2'd1);
        record_step(32'h01, 1'b0);
        record_step(32'h01, 1'b1);
        check("c state done", state, 2'd3);
        check("c fill", fill_count, 3);
        step();
        check("c valid", rd_valid, 1'b1);
        debug_enable = 1'b0;
        rd_ready = 1'b1;
        repeat (3) step();
        check("c frozen fill", fill_count, 3);
        check("c frozen valid", rd_valid, 1'b1);
        check("c frozen cnt", main_cycle_cnt, tb_cyc);
        rd_ready = 1'b0;
        debug_enable = 1'b1;
        drain(1'b0, "c");

        // Reset in the middle of POST
        change_only = 1'b0;
        ch_mask = 8'hFF;
        post_cnt = 6'd5;
        arm = 1'b1;
        step();
        arm = 1'b0;
        probe = 32'h11;
        step();
        step();
        trig_in = 1'b1;
        step();
        trig_in = 1'b0;
        step();
        check("r in post", state, 2'd2);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("r state", state, 2'd0);
        check("r valid", rd_valid, 1'b0);
        check("r cnt", main_cycle_cnt, 32'd0);
        check("r fill", fill_count, 0);
        check("r wrapped", wrapped, 1'b0);
        step();
        check("r idle after", state, 2'd0);
        check("r cnt resumes", main_cycle_cnt, tb_cyc);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
